// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the ROM read arbiter.
// Covers the FSM state encoding, default parameters and the requester ID width helper.
package rom_arb_pkg;

  localparam int unsigned DefNumReq       = 4;
  localparam int unsigned DefDataWidth    = 8;
  localparam int unsigned DefAddressWidth = 3;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } rom_arb_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request arbiter with a one-hot grant and an encoded index.
// Defining ROM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority and removes last_grant.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned IdW = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdW-1:0]     grant_idx
);

`ifdef ROM_ARB_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, advance};

  // Descending scan so the lowest-index request is written last and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IdW'(i);
      end
    end
  end

`else

  logic [IdW-1:0] last_grant_q, last_grant_d;
  int unsigned    idx;
  logic           found;

  // Search begins one past the previous winner, wrapping modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IdW'(idx);
      end
    end
    last_grant_d = advance ? grant_idx : last_grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IdW'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

`endif

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one registered-output ROM between NUM_REQ requesters, one read in flight at a time.
// Arbitration policy is set in rr_arbiter (ROM_ARB_FIXED_PRIO_EN selects fixed priority).
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DefNumReq,
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned ADDRESS_WIDTH = DefAddressWidth,
  localparam int unsigned IdW = id_width(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [IdW-1:0]                   rsp_id,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rom_en,
  output logic [ADDRESS_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]            rom_dout
);

  rom_arb_state_e          state_q, state_d;
  logic [IdW-1:0]          id_q, id_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]      grant;
  logic [IdW-1:0]          grant_idx;
  logic                    advance;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    data_d    = data_q;
    req_ready = '0;
    rom_en    = 1'b0;
    rom_addr  = '0;
    rsp_valid = 1'b0;
    advance   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          req_ready = grant;
          rom_en    = 1'b1;
          rom_addr  = req_addr[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          id_d      = grant_idx;
          advance   = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        // ROM output is only valid here, one cycle after the enabled edge.
        data_d  = rom_dout;
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Grants must not leak out while reset is held in IDLE.
    if (rst) begin
      req_ready = '0;
      rom_en    = 1'b0;
      rom_addr  = '0;
      rsp_valid = 1'b0;
      advance   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign rsp_id   = id_q;
  assign rsp_data = data_q;

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Shares one single-port, registered-output ROM between `NUM_REQ` independent requesters. It arbitrates read requests, drives the ROM enable and address, and captures the ROM output. It returns the data with the ID of the requester that issued it. It sits between requester logic (sequencers, table-lookup engines) and the ROM instance; at most one read is in flight.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2
- `DATA_WIDTH`, 8: ROM word width
- `ADDRESS_WIDTH`, 3: ROM address width
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester read request
- `req_addr`  in  NUM_REQ*ADDRESS_WIDTH  flattened addresses; requester i uses bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- `req_ready`  out  NUM_REQ  one-hot grant; request i accepted when `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  1  response data valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  $clog2(NUM_REQ)  index of requester owning `rsp_data`
- `rsp_data`  out  DATA_WIDTH  captured ROM word
- `rom_en`  out  1  ROM enable
- `rom_addr`  out  ADDRESS_WIDTH  ROM address
- `rom_dout`  in  DATA_WIDTH  ROM registered output; high-Z when not enabled

## Operation
- Three-state FSM: IDLE, WAIT, RESP.
- IDLE:
  - When any `req_valid` is high, the arbiter picks winner g and asserts `req_ready[g]` combinationally in the same cycle.
  - `rom_en`=1 and `rom_addr`=`req_addr[g]` in that same cycle.
  - g is latched into the ID register and the FSM moves to WAIT.
  - With no request: `req_ready`=0, `rom_en`=0, stay in IDLE.
- WAIT: `rom_en`=0, `req_ready`=0. `rom_dout` is captured into `rsp_data` at the closing edge, then go to RESP.
- RESP:
  - `rsp_valid`=1 while `rsp_data` and `rsp_id` are held stable.
  - On `rsp_valid & rsp_ready`, return to IDLE.
  - No new grant is issued in RESP, including the handshake cycle.
- Round-robin arbitration:
  - Search starts at `last_grant+1` modulo NUM_REQ; the first set `req_valid` wins.
  - `last_grant` updates to g on acceptance only.
- `req_ready` is never asserted to a requester whose `req_valid` is low. At most one bit is set.
- `rom_dout` is sampled only at the end of WAIT, so the high-Z value driven while the ROM is disabled is never captured.
- A requester may drop `req_valid` before it is granted; no state is affected.

## Timing
- Reset values:
  - state IDLE; `last_grant`=NUM_REQ-1, so requester 0 has first priority.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `req_ready`=0, `rom_en`=0, `rom_addr`=0.
- Latency: request accepted in cycle T, then `rsp_valid`=1 in cycle T+2.
- Best-case throughput is one read per 3 cycles, with `rsp_ready` held high.
- `rsp_ready` low in RESP stalls indefinitely; outputs are held and no ROM access occurs.
- Reset asserted mid-operation (WAIT or RESP): the in-flight read is dropped, outputs take their reset values immediately, and no response is issued after release.
- The first grant is possible in the first cycle after reset deassertion.

## Configuration
- `ROM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, the lowest-index valid requester always wins, and `last_grant` is not implemented.
  - Undefined (default): round-robin as above.

## Structure
- Package `rom_arb_pkg`:
  - `rom_arb_state_e` (IDLE, WAIT, RESP).
  - Default parameter constants.
  - A function computing the ID width `$clog2(NUM_REQ)`.
- Sub-module `rr_arbiter`:
  - Parameter `NUM_REQ`.
  - Inputs `clk`, `rst`, `req`, `advance`; outputs `grant` (one-hot) and `grant_idx`.
  - Owns `last_grant` and the `ROM_ARB_FIXED_PRIO_EN` selection.
- The top level holds the FSM, ID/data registers and the address mux.

## Test plan
The bench uses a ROM model with registered output and contents mem[a] = 8'hA0 + a.

- Single request: requester 2 requests addr 5, `rsp_ready`=1.
  - Expect `req_ready`=4'b0100 in T and `rom_en`=1, `rom_addr`=5 in T.
  - Expect `rsp_valid` in T+2 with `rsp_id`=2, `rsp_data`=8'hA5.
- Round-robin fairness: all 4 requesters held valid with addr = index, `rsp_ready`=1.
  - Expect grant order 0,1,2,3,0 at 3-cycle spacing and data A0,A1,A2,A3,A0.
  - With the macro defined: requester 0 wins every grant.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid`, `rsp_id` and `rsp_data` stay stable; `rom_en`=0 and `req_ready`=0 throughout.
  - Completes one cycle after `rsp_ready` rises.
- Reset mid-read: assert `rst` during WAIT.
  - Outputs go to reset values asynchronously and no `rsp_valid` follows.
  - The next request from requester 1 after release gets the first grant if requester 0 is idle.
- Withdrawn request: requester 3 raises then drops `req_valid` while in RESP.
  - It is never granted; `last_grant` is unchanged.
- Idle: no `req_valid` for 10 cycles, so `rom_en`=0 and `rsp_valid`=0 throughout.
